mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive instruction-fetch losses tolerated before fetch is forced to win.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port if_req, input, 1, fetch read request, held until if_ack.
REQ-005 SHALL have port if_addr, input, 32, fetch address.
REQ-006 SHALL have port if_rdata, output, 32, fetch read data.
REQ-007 SHALL have port if_ack, output, 1, fetch completion pulse.
REQ-008 SHALL have port mem_req, input, 1, data-stage request, held until mem_ack.
REQ-009 SHALL have port mem_wr, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port mem_addr, input, 32, data address.
REQ-011 SHALL have port mem_wdata, input, 32, store data.
REQ-012 SHALL have port mem_rdata, output, 32, load data.
REQ-013 SHALL have port mem_ack, output, 1, data completion pulse.
REQ-014 SHALL have port bus_req, output, 1, shared memory port request.
REQ-015 SHALL have ports bus_wr (output, 1), bus_addr (output, 32) and bus_wdata (output, 32), the shared port command.
REQ-016 SHALL have ports bus_rdata (input, 32) and bus_ready (input, 1), the shared port response; bus_ready is sampled only while bus_req=1.
REQ-017 SHALL have ports if_stall and mem_stall, outputs, 1 each, defined as req AND NOT ack per port (combinational).

Function
REQ-018 SHALL implement the FSM states IDLE, GNT_IF and GNT_MEM.
REQ-019 In IDLE, a port is eligible when its req=1 and its ack is not asserted in that cycle.
REQ-020 In IDLE, SHALL go to GNT_MEM when mem is eligible and (starve_cnt<STARVE_MAX or fetch not eligible); otherwise SHALL go to GNT_IF when fetch is eligible; otherwise SHALL stay in IDLE.
REQ-021 On the grant edge, SHALL latch the winner's addr, wdata and wr (wr=0 for fetch) into bus_addr, bus_wdata and bus_wr; these SHALL be held stable through the GNT state.
REQ-022 bus_req SHALL be 1 exactly while in GNT_IF or GNT_MEM (registered; first asserted the cycle after the IDLE decision).
REQ-023 In a GNT state, on a cycle with bus_ready=1, SHALL return to IDLE and, on the same edge, capture bus_rdata into the winner's rdata register (mem_rdata only when bus_wr=0).
REQ-024 SHALL assert the winner's ack for exactly one cycle, the cycle after bus_ready; rdata SHALL hold until that port's next read completion.
REQ-025 Minimum latency: req eligible in cycle N, bus_ready=1 in N+1 -> ack in N+2; each extra bus wait cycle adds one.
REQ-026 starve_cnt (width log2(STARVE_MAX)+1) SHALL increment, saturating at STARVE_MAX, on each GNT_MEM entry while if_req=1, and clear on each GNT_IF entry.
REQ-027 Simultaneous if_req and mem_req with starve_cnt=STARVE_MAX SHALL grant fetch.
REQ-028 Requests deasserted while not granted SHALL be dropped silently; changes to req, addr or wdata during a GNT state SHALL NOT affect the bus command.
REQ-029 At most one ack SHALL be asserted in any cycle, and never both bus grants.

Reset
REQ-030 While rst=1: state=IDLE, bus_req=0, bus_wr=0, bus_addr=0, bus_wdata=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, starve_cnt=0, all asynchronously.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no ack; after release the first grant follows REQ-020.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x100, bus_ready=1 on first bus_req cycle, bus_rdata=0x00000013 -> bus_addr=0x100, bus_wr=0, if_ack pulse 2 cycles after request, if_rdata=0x00000013.
REQ-033 Store with 3 wait cycles: mem_req=1, mem_wr=1, mem_addr=0x200, mem_wdata=0xDEADBEEF -> bus_wr=1 and command stable for 4 bus_req cycles, mem_ack one cycle after bus_ready, mem_rdata unchanged.
REQ-034 Contention: if_req and mem_req held continuously, STARVE_MAX=4 -> grant order MEM,MEM,MEM,MEM,IF repeating; starve_cnt returns to 0 after each IF grant.
REQ-035 Back-to-back: mem_req dropped on its ack, if_req pending -> IF granted in the ack cycle's IDLE decision, no duplicate mem grant.
REQ-036 Reset during GNT_MEM with bus_ready=0 -> bus_req falls immediately, no mem_ack, all outputs at REQ-030 values.
REQ-037 Assertion checks throughout: at most one ack per cycle, bus_addr stable while bus_req=1 and bus_ready=0.

Source files
------------

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port arbiter sharing one memory bus between fetch and data stage
//
// Purpose: grants the shared memory port to either the instruction-fetch port
// or the data-stage port. The data stage normally wins. A starvation counter
// forces fetch to win once it has lost STARVE_MAX grants in a row.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch read request (held until if_ack)
//   if_rdata/if_ack          fetch read data, one-cycle completion pulse
//   mem_req/mem_wr/mem_addr/mem_wdata
//                            data-stage load/store request (held until mem_ack)
//   mem_rdata/mem_ack        load data, one-cycle completion pulse
//   bus_req/bus_wr/bus_addr/bus_wdata
//                            registered shared-port command
//   bus_rdata/bus_ready      shared-port response, sampled only while bus_req=1
//   if_stall/mem_stall       req AND NOT ack per port
module mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        if_stall,
  output logic        mem_stall
);

  localparam int CNT_W = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              bus_wr_q, bus_wr_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  // A port whose ack is high this cycle still shows req (held until ack), so
  // it must not be re-granted for the request that is just completing.
  logic if_elig, mem_elig;
  assign if_elig  = if_req & ~if_ack_q;
  assign mem_elig = mem_req & ~mem_ack_q;

  always_comb begin
    state_d      = state_q;
    bus_wr_d     = bus_wr_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (mem_elig && ((starve_cnt_q < STARVE_LIM) || !if_elig)) begin
          state_d     = GNT_MEM;
          bus_wr_d    = mem_wr;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          // Counts every data grant taken while fetch is asking, saturating.
          if (if_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (if_elig) begin
          state_d      = GNT_IF;
          bus_wr_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_wdata_d  = 32'h0;
          starve_cnt_d = '0;
        end
      end
      GNT_IF: begin
        if (bus_ready) begin
          state_d    = IDLE;
          if_rdata_d = bus_rdata;
          if_ack_d   = 1'b1;
        end
      end
      GNT_MEM: begin
        if (bus_ready) begin
          state_d   = IDLE;
          mem_ack_d = 1'b1;
          if (!bus_wr_q) begin
            mem_rdata_d = bus_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rdata_q   <= 32'h0;
      mem_rdata_q  <= 32'h0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // bus_req decodes the state register directly, so reset drops it at once.
  assign bus_req   = (state_q == GNT_IF) || (state_q == GNT_MEM);
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        if_stall;
  logic        mem_stall;

  int n_vec = 0;
  int n_err = 0;

  mem_arb #(.STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_req   (bus_req),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .if_stall  (if_stall),
    .mem_stall (mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        rdy;
    logic [31:0] rd;
    logic        ebr;
    logic        ebw;
    logic [31:0] eba;
    logic [31:0] ebwd;
    logic        eia;
    logic        ema;
    logic [31:0] eir;
    logic [31:0] emr;
    logic        eis;
    logic        ems;
  } vec_t;

  function automatic vec_t v(
    input logic rst_i, input logic ir, input logic [31:0] ia,
    input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] mwd,
    input logic rdy, input logic [31:0] rd,
    input logic ebr, input logic ebw, input logic [31:0] eba, input logic [31:0] ebwd,
    input logic eia, input logic ema, input logic [31:0] eir, input logic [31:0] emr,
    input logic eis, input logic ems);
    vec_t r;
    r.rst = rst_i; r.ir = ir; r.ia = ia; r.mr = mr; r.mw = mw; r.ma = ma;
    r.mwd = mwd; r.rdy = rdy; r.rd = rd; r.ebr = ebr; r.ebw = ebw; r.eba = eba;
    r.ebwd = ebwd; r.eia = eia; r.ema = ema; r.eir = eir; r.emr = emr;
    r.eis = eis; r.ems = ems;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Continuous protocol checks: never two acks, command stable during waits.
  logic        prev_breq = 1'b0;
  logic        prev_rdy  = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      prev_breq <= 1'b0;
    end else begin
      if (if_ack && mem_ack) begin
        n_err++;
        $display("FAIL two_acks: if_ack=%b mem_ack=%b, expected at most one", if_ack, mem_ack);
      end
      if (prev_breq && !prev_rdy && bus_req && (bus_addr !== prev_addr)) begin
        n_err++;
        $display("FAIL addr_stable: got %h, expected %h", bus_addr, prev_addr);
      end
      prev_breq <= bus_req;
      prev_rdy  <= bus_ready;
      prev_addr <= bus_addr;
    end
  end

  vec_t vecs[17];
  int   starve;
  logic exp_mem;

  initial begin
    vecs[0]  = v(1, 0,0,       0,0,0,0,                0,0,           0,0,0,0,                 0,0,0,0,                      0,0);
    // fetch only, zero wait states
    vecs[1]  = v(0, 1,'h100,   0,0,0,0,                0,0,           0,0,0,0,                 0,0,0,0,                      1,0);
    vecs[2]  = v(0, 1,'h100,   0,0,0,0,                1,'h13,        1,0,'h100,0,             0,0,0,0,                      1,0);
    vecs[3]  = v(0, 1,'h100,   0,0,0,0,                0,0,           0,0,'h100,0,             1,0,'h13,0,                   0,0);
    vecs[4]  = v(0, 0,0,       0,0,0,0,                0,0,           0,0,'h100,0,             0,0,'h13,0,                   0,0);
    // store with three wait states; inputs wobble mid-grant
    vecs[5]  = v(0, 0,0,       1,1,'h200,'hDEADBEEF,   0,0,           0,0,'h100,0,             0,0,'h13,0,                   0,1);
    vecs[6]  = v(0, 0,0,       1,1,'h200,'hDEADBEEF,   0,0,           1,1,'h200,'hDEADBEEF,    0,0,'h13,0,                   0,1);
    vecs[7]  = v(0, 0,0,       1,1,'h999,0,            0,0,           1,1,'h200,'hDEADBEEF,    0,0,'h13,0,                   0,1);
    vecs[8]  = v(0, 0,0,       1,0,'h999,0,            0,0,           1,1,'h200,'hDEADBEEF,    0,0,'h13,0,                   0,1);
    vecs[9]  = v(0, 0,0,       1,1,'h200,'hDEADBEEF,   1,'hBAD0BAD0,  1,1,'h200,'hDEADBEEF,    0,0,'h13,0,                   0,1);
    vecs[10] = v(0, 0,0,       1,1,'h200,'hDEADBEEF,   0,0,           0,1,'h200,'hDEADBEEF,    0,1,'h13,0,                   0,0);
    // load wins contention, then fetch granted in the load's ack cycle
    vecs[11] = v(0, 1,'h104,   1,0,'h300,0,            0,0,           0,1,'h200,'hDEADBEEF,    0,0,'h13,0,                   1,1);
    vecs[12] = v(0, 1,'h104,   1,0,'h300,0,            1,'h11111111,  1,0,'h300,0,             0,0,'h13,0,                   1,1);
    vecs[13] = v(0, 1,'h104,   1,0,'h300,0,            0,0,           0,0,'h300,0,             0,1,'h13,'h11111111,          1,0);
    vecs[14] = v(0, 1,'h104,   0,0,0,0,                1,'h22222222,  1,0,'h104,0,             0,0,'h13,'h11111111,          1,0);
    vecs[15] = v(0, 1,'h104,   0,0,0,0,                0,0,           0,0,'h104,0,             1,0,'h22222222,'h11111111,    0,0);
    vecs[16] = v(0, 0,0,       0,0,0,0,                0,0,           0,0,'h104,0,             0,0,'h22222222,'h11111111,    0,0);

    for (int i = 0; i < 17; i++) begin
      rst       = vecs[i].rst;
      if_req    = vecs[i].ir;
      if_addr   = vecs[i].ia;
      mem_req   = vecs[i].mr;
      mem_wr    = vecs[i].mw;
      mem_addr  = vecs[i].ma;
      mem_wdata = vecs[i].mwd;
      bus_ready = vecs[i].rdy;
      bus_rdata = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("row%0d.bus_req", i),   32'(bus_req),   32'(vecs[i].ebr));
      chk($sformatf("row%0d.bus_wr", i),    32'(bus_wr),    32'(vecs[i].ebw));
      chk($sformatf("row%0d.bus_addr", i),  bus_addr,       vecs[i].eba);
      chk($sformatf("row%0d.bus_wdata", i), bus_wdata,      vecs[i].ebwd);
      chk($sformatf("row%0d.if_ack", i),    32'(if_ack),    32'(vecs[i].eia));
      chk($sformatf("row%0d.mem_ack", i),   32'(mem_ack),   32'(vecs[i].ema));
      chk($sformatf("row%0d.if_rdata", i),  if_rdata,       vecs[i].eir);
      chk($sformatf("row%0d.mem_rdata", i), mem_rdata,      vecs[i].emr);
      chk($sformatf("row%0d.if_stall", i),  32'(if_stall),  32'(vecs[i].eis));
      chk($sformatf("row%0d.mem_stall", i), 32'(mem_stall), 32'(vecs[i].ems));
      next_cycle();
    end

    // Contention: both ports request together at each decision. The loser
    // withdraws while the winner is on the bus, so every decision sees both.
    // Expected order MEM x4, IF, repeating; 14 rounds leave the counter at 4.
    if_addr   = 32'h1000;
    mem_addr  = 32'h2000;
    mem_wr    = 1'b0;
    mem_wdata = 32'h0;
    bus_rdata = 32'h0;
    starve    = 0;
    for (int k = 0; k < 14; k++) begin
      exp_mem   = (starve < 4);
      if (exp_mem) starve = starve + 1; else starve = 0;
      if_req    = 1'b1;
      mem_req   = 1'b1;
      bus_ready = 1'b0;
      next_cycle();
      if (exp_mem) if_req = 1'b0; else mem_req = 1'b0;
      bus_ready = 1'b1;
      bus_rdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("cont%0d.bus_req", k), 32'(bus_req), 32'h1);
      chk($sformatf("cont%0d.winner_addr", k), bus_addr, exp_mem ? 32'h2000 : 32'h1000);
      next_cycle();
      bus_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("cont%0d.if_ack", k),  32'(if_ack),  exp_mem ? 32'h0 : 32'h1);
      chk($sformatf("cont%0d.mem_ack", k), 32'(mem_ack), exp_mem ? 32'h1 : 32'h0);
      chk($sformatf("cont%0d.rdata", k), exp_mem ? mem_rdata : if_rdata, 32'hA000_0000 + 32'(k));
      next_cycle();
      if_req  = 1'b0;
      mem_req = 1'b0;
      next_cycle();
    end

    // Reset during a store that is waiting on the bus.
    mem_req   = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 32'h400;
    mem_wdata = 32'h55;
    next_cycle();
    #2;
    chk("rst.pre_bus_req", 32'(bus_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst.bus_req",   32'(bus_req),   32'h0);
    chk("rst.bus_wr",    32'(bus_wr),    32'h0);
    chk("rst.bus_addr",  bus_addr,       32'h0);
    chk("rst.bus_wdata", bus_wdata,      32'h0);
    chk("rst.if_ack",    32'(if_ack),    32'h0);
    chk("rst.mem_ack",   32'(mem_ack),   32'h0);
    chk("rst.if_rdata",  if_rdata,       32'h0);
    chk("rst.mem_rdata", mem_rdata,      32'h0);
    next_cycle();
    rst     = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    chk("rst.after_mem_ack", 32'(mem_ack), 32'h0);
    chk("rst.after_bus_req", 32'(bus_req), 32'h0);
    next_cycle();
    // The cleared starvation counter lets the data port win again.
    if_req   = 1'b1;
    mem_req  = 1'b1;
    mem_wr   = 1'b0;
    mem_addr = 32'h2000;
    next_cycle();
    if_req    = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = 32'h0000_BEEF;
    @(negedge clk);
    chk("post_rst.winner_addr", bus_addr, 32'h2000);
    next_cycle();
    bus_ready = 1'b0;
    @(negedge clk);
    chk("post_rst.mem_ack",   32'(mem_ack), 32'h1);
    chk("post_rst.mem_rdata", mem_rdata,    32'h0000_BEEF);
    next_cycle();
    mem_req = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
